// File: rtl/alu593_op_issue.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu593_op_issue                                                 |
// | Purpose  : Issue stage for the ALU593 datapath. Buffers {op, A, B}         |
// |            commands in a small FIFO. Drops no-op and reserved encodings.   |
// |            Dispatches one legal op at a time over a start/done handshake.  |
// |            A watchdog supervises each dispatched op, and completed ops are |
// |            counted.                                                        |
// | Ports    : clk_i, rst_ni (async, active low)                               |
// |            in_valid_i/in_ready_o/in_op_i/in_a_i/in_b_i : command input     |
// |            alu_start_o/alu_op_o/alu_a_o/alu_b_o/alu_done_i : ALU handshake |
// |            err_illegal_o, err_timeout_o : one-cycle error pulses           |
// |            busy_o, issued_cnt_o : status                                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module alu593_op_issue #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        in_op_i,
  input  logic [DATA_W-1:0] in_a_i,
  input  logic [DATA_W-1:0] in_b_i,
  output logic              alu_start_o,
  output logic [3:0]        alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic              alu_done_i,
  output logic              err_illegal_o,
  output logic              err_timeout_o,
  output logic              busy_o,
  output logic [7:0]        issued_cnt_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = 2 * DATA_W + 4;
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             full, empty, push, pop;
  logic [ENT_W-1:0] head;
  logic [3:0]       head_op;
  logic [DATA_W-1:0] head_a, head_b;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Ready reflects the pre-pop occupancy only, so a full FIFO never accepts.
  assign in_ready_o = !full;
  assign push       = in_valid_i && !full;

  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign head_op = head[ENT_W-1 -: 4];
  assign head_a  = head[2*DATA_W-1 -: DATA_W];
  assign head_b  = head[DATA_W-1:0];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_op_i, in_a_i, in_b_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ------------------------------------------------------------ dispatch FSM
  state_t            state_q, state_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic              start_q, start_d;
  logic              ill_q, ill_d;
  logic              to_q, to_d;
  logic [7:0]        wd_q, wd_d;
  logic [7:0]        cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      start_q  <= 1'b0;
      ill_q    <= 1'b0;
      to_q     <= 1'b0;
      wd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      start_q  <= start_d;
      ill_q    <= ill_d;
      to_q     <= to_d;
      wd_q     <= wd_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    start_d  = 1'b0;
    ill_d    = 1'b0;
    to_d     = 1'b0;
    wd_d     = wd_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_op == 4'h0 || head_op == 4'hF) begin
            // no-op encodings are dropped without any indication
          end else if (head_op >= 4'hA) begin
            ill_d = 1'b1;
          end else begin
            alu_op_d = head_op;
            alu_a_d  = head_a;
            alu_b_d  = head_b;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        start_d = 1'b1;
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (alu_done_i) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_IDLE;
        end else if (wd_q == WD_LAST) begin
          to_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign alu_start_o   = start_q;
  assign alu_op_o      = alu_op_q;
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign err_illegal_o = ill_q;
  assign err_timeout_o = to_q;
  assign issued_cnt_o  = cnt_q;
  assign busy_o        = !empty || (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu593_op_issue.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu593_op_issue                                              |
// | Purpose  : Directed self-checking bench for alu593_op_issue with a simple  |
// |            ALU responder of programmable latency.                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_alu593_op_issue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [7:0] in_a, in_b;
  logic       alu_start;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic       alu_done;
  logic       err_illegal, err_timeout, busy;
  logic [7:0] issued_cnt;

  always #5 clk = ~clk;

  alu593_op_issue #(.DATA_W(8), .DEPTH(4), .TIMEOUT(15)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_op_i      (in_op),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .alu_start_o  (alu_start),
    .alu_op_o     (alu_op),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_done_i   (alu_done),
    .err_illegal_o(err_illegal),
    .err_timeout_o(err_timeout),
    .busy_o       (busy),
    .issued_cnt_o (issued_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ----------------------------------------------------- ALU responder/monitor
  int         resp_en  = 0;
  int         resp_lat = 2;
  int         pend     = 0;
  int         n_start  = 0;
  int         n_ill    = 0;
  int         n_to     = 0;
  time        t_start  = 0;
  time        t_to     = 0;
  logic [3:0] st_op[$];
  logic [7:0] st_a[$];
  logic [7:0] st_b[$];

  initial begin
    alu_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        pend     = 0;
        alu_done = 1'b0;
      end else begin
        alu_done = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) alu_done = 1'b1;
        end
        if (alu_start) begin
          n_start++;
          st_op.push_back(alu_op);
          st_a.push_back(alu_a);
          st_b.push_back(alu_b);
          t_start = $time - 2;
          if (resp_en != 0) pend = resp_lat;
        end
        if (err_illegal) n_ill++;
        if (err_timeout) begin
          n_to++;
          t_to = $time - 2;
        end
      end
    end
  end

  // ------------------------------------------------------------ driver tasks
  time t_acc = 0;

  task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    while (!in_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("push_ready_wait", (t >= 200) ? 32'd1 : 32'd0, 32'd0);
    @(posedge clk);
    t_acc = $time;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_starts(input int n);
    int t = 0;
    while (n_start < n && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("wait_start", (n_start >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int limit);
    int t = 0;
    while (busy && t < limit) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("wait_idle", busy ? 32'd1 : 32'd0, 32'd0);
    // let trailing error pulses reach the monitor
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ------------------------------------------------------------------ stimulus
  int s0, i0, c0, to0;
  time ts_mul;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_op    = '0;
    in_a     = '0;
    in_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_start", 32'(alu_start), 32'd0);
    check_eq("rst_cnt", 32'(issued_cnt), 32'd0);
    check_eq("rst_alu_op", 32'(alu_op), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single add, done two cycles after start
    resp_en  = 1;
    resp_lat = 2;
    push(4'h1, 8'h12, 8'h34);
    wait_starts(1);
    check_eq("t1_latency", 32'(t_start - t_acc), 32'd20);
    check_eq("t1_op", 32'(st_op[0]), 32'h1);
    check_eq("t1_a", 32'(st_a[0]), 32'h12);
    check_eq("t1_b", 32'(st_b[0]), 32'h34);
    wait_idle(100);
    check_eq("t1_cnt", 32'(issued_cnt), 32'd1);

    // 3: no_op and reserved entries are filtered
    s0 = n_start;
    i0 = n_ill;
    push(4'h0, 8'h01, 8'h02);
    push(4'hC, 8'h03, 8'h04);
    push(4'h3, 8'h55, 8'hAA);
    wait_idle(100);
    check_eq("t3_ill_pulses", 32'(n_ill - i0), 32'd1);
    check_eq("t3_starts", 32'(n_start - s0), 32'd1);
    check_eq("t3_op", 32'(st_op[s0]), 32'h3);
    check_eq("t3_a", 32'(st_a[s0]), 32'h55);
    check_eq("t3_b", 32'(st_b[s0]), 32'hAA);
    check_eq("t3_cnt", 32'(issued_cnt), 32'd2);

    // 4 + 2: hanging op times out while a burst backs up behind it
    resp_en = 0;
    s0  = n_start;
    to0 = n_to;
    c0  = int'(issued_cnt);
    push(4'h4, 8'h07, 8'h09);
    wait_starts(s0 + 1);
    ts_mul  = t_start;
    resp_en = 1;
    push(4'h5, 8'h10, 8'h20);
    push(4'h6, 8'h11, 8'h21);
    push(4'h7, 8'h12, 8'h22);
    push(4'h8, 8'h13, 8'h23);
    check_eq("t2_full_ready", 32'(in_ready), 32'd0);
    check_eq("t2_busy", 32'(busy), 32'd1);
    push(4'h9, 8'h14, 8'h24);
    check_eq("t2_fifth_accept", 32'(t_acc - ts_mul), 32'd170);
    check_eq("t4_to_pulses", 32'(n_to - to0), 32'd1);
    check_eq("t4_to_time", 32'(t_to - ts_mul), 32'd150);
    wait_idle(300);
    check_eq("t4_cnt", 32'(issued_cnt), 32'(c0 + 5));
    check_eq("t2_starts", 32'(n_start - s0), 32'd6);
    for (int k = 0; k < 5; k++) begin
      check_eq("t2_order", 32'(st_op[s0 + 1 + k]), 32'(5 + k));
    end

    // 5: asynchronous reset while waiting on the ALU
    resp_en = 0;
    s0 = n_start;
    to0 = n_to;
    push(4'h2, 8'hC3, 8'h3C);
    wait_starts(s0 + 1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t5_op", 32'(alu_op), 32'd0);
    check_eq("t5_a", 32'(alu_a), 32'd0);
    check_eq("t5_cnt", 32'(issued_cnt), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_eq("t5_busy_after", 32'(busy), 32'd0);
    check_eq("t5_ready_after", 32'(in_ready), 32'd1);
    check_eq("t5_no_timeout", 32'(n_to - to0), 32'd0);

    // 6: 256 completions wrap the counter and the FIFO pointers
    resp_en  = 1;
    resp_lat = 1;
    s0 = n_start;
    i0 = n_ill;
    for (int i = 0; i < 256; i++) begin
      push(4'(1 + (i % 9)), 8'(i), 8'(i) ^ 8'h5A);
    end
    wait_idle(500);
    check_eq("t6_cnt_wrap", 32'(issued_cnt), 32'd0);
    check_eq("t6_starts", 32'(n_start - s0), 32'd256);
    check_eq("t6_no_ill", 32'(n_ill - i0), 32'd0);
    for (int i = 0; i < 256; i++) begin
      if (s0 + i < st_op.size()) begin
        check_eq("t6_entry", {12'd0, st_op[s0 + i], st_a[s0 + i], st_b[s0 + i]},
                 {12'd0, 4'(1 + (i % 9)), 8'(i), 8'(i) ^ 8'h5A});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
